// File: rtl/vm_change_dispenser.sv
// Coin payout unit: converts a change amount into type-1/type-2 eject pulses,
// drawing from an internal saturating coin inventory and reporting any shortfall.
module vm_change_dispenser #(
    parameter int AMT_W     = 4,
    parameter int CNT_W     = 4,
    parameter int PULSE_LEN = 2,
    parameter int GAP_LEN   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [AMT_W-1:0] req_amt,
    output logic             req_ready,
    input  logic             refill_1,
    input  logic             refill_2,
    output logic             out_1,
    output logic             out_2,
    output logic             busy,
    output logic             done,
    output logic [AMT_W-1:0] short_amt,
    output logic [CNT_W-1:0] cnt_1,
    output logic [CNT_W-1:0] cnt_2
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PICK  = 3'd1;
    localparam logic [2:0] S_PULSE = 3'd2;
    localparam logic [2:0] S_GAP   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [3:0] PULSE_T = 4'(PULSE_LEN - 1);
    localparam logic [3:0] GAP_T   = 4'(GAP_LEN - 1);

    logic [2:0]       state;
    logic [AMT_W-1:0] remaining;
    logic [3:0]       timer;
    logic             pick_2;
    logic             pick_1;

    // Greedy choice: a type-2 coin whenever it fits and is stocked, else type-1.
    always_comb begin
        pick_2 = 1'b0;
        pick_1 = 1'b0;
        if (state == S_PICK) begin
            pick_2 = (remaining >= AMT_W'(2)) && (cnt_2 != '0);
            pick_1 = !pick_2 && (remaining != '0) && (cnt_1 != '0);
        end
    end

    // Simultaneous refill and eject cancel, even when the counter is saturated.
    function automatic logic [CNT_W-1:0] inv_next(input logic [CNT_W-1:0] cnt,
                                                  input logic inc, input logic dec);
        if (inc && !dec && cnt != '1)
            return cnt + CNT_W'(1);
        else if (dec && !inc)
            return cnt - CNT_W'(1);
        else
            return cnt;
    endfunction

    assign busy      = (state != S_IDLE);
    assign req_ready = (state == S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            remaining <= '0;
            timer     <= '0;
            out_1     <= 1'b0;
            out_2     <= 1'b0;
            done      <= 1'b0;
            short_amt <= '0;
            cnt_1     <= '0;
            cnt_2     <= '0;
        end else begin
            cnt_1 <= inv_next(cnt_1, refill_1, pick_1);
            cnt_2 <= inv_next(cnt_2, refill_2, pick_2);
            done  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        remaining <= req_amt;
                        state     <= S_PICK;
                    end
                end
                S_PICK: begin
                    if (pick_2) begin
                        remaining <= remaining - AMT_W'(2);
                        out_2     <= 1'b1;
                        timer     <= PULSE_T;
                        state     <= S_PULSE;
                    end else if (pick_1) begin
                        remaining <= remaining - AMT_W'(1);
                        out_1     <= 1'b1;
                        timer     <= PULSE_T;
                        state     <= S_PULSE;
                    end else begin
                        short_amt <= remaining;
                        done      <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_PULSE: begin
                    if (timer == '0) begin
                        out_1 <= 1'b0;
                        out_2 <= 1'b0;
                        timer <= GAP_T;
                        state <= S_GAP;
                    end else begin
                        timer <= timer - 4'd1;
                    end
                end
                S_GAP: begin
                    if (timer == '0)
                        state <= S_PICK;
                    else
                        timer <= timer - 4'd1;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vm_change_dispenser.sv
// Scoreboard bench for vm_change_dispenser: expected coin sequence and done
// results are queued on each request and compared as the DUT produces them.
module tb_vm_change_dispenser;

    localparam int AMT_W     = 4;
    localparam int CNT_W     = 4;
    localparam int PULSE_LEN = 2;
    localparam int GAP_LEN   = 1;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req_valid = 1'b0;
    logic [AMT_W-1:0] req_amt = '0;
    logic             req_ready;
    logic             refill_1 = 1'b0;
    logic             refill_2 = 1'b0;
    logic             out_1, out_2, busy, done;
    logic [AMT_W-1:0] short_amt;
    logic [CNT_W-1:0] cnt_1, cnt_2;

    vm_change_dispenser #(
        .AMT_W(AMT_W), .CNT_W(CNT_W), .PULSE_LEN(PULSE_LEN), .GAP_LEN(GAP_LEN)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_amt(req_amt),
        .req_ready(req_ready), .refill_1(refill_1), .refill_2(refill_2),
        .out_1(out_1), .out_2(out_2), .busy(busy), .done(done),
        .short_amt(short_amt), .cnt_1(cnt_1), .cnt_2(cnt_2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, actual, expected, cyc);
        end
    endtask

    typedef struct { int sh; int cyc; } done_t;
    int    coinq[$];
    done_t doneq[$];
    int    m1 = 0;
    int    m2 = 0;

    // Monitor: outputs sampled on the falling edge, away from the active edge.
    bit p1 = 0, p2 = 0;
    int w = 0;
    always @(negedge clk) begin
        if (rst) begin
            p1 = 0; p2 = 0; w = 0;
        end else begin
            if (out_1 && out_2) check_eq("excl", 1, 0);
            if ((out_1 && !p1) || (out_2 && !p2)) begin
                if (coinq.size() == 0) check_eq("coin_unexp", out_2 ? 2 : 1, 0);
                else check_eq("coin_type", out_2 ? 2 : 1, coinq.pop_front());
            end
            if (out_1 || out_2) w++;
            else if (p1 || p2) begin
                check_eq("pulse_w", w, PULSE_LEN);
                w = 0;
            end
            if (done) begin
                if (doneq.size() == 0) check_eq("done_unexp", 1, 0);
                else begin
                    done_t d;
                    d = doneq.pop_front();
                    check_eq("short_amt", int'(short_amt), d.sh);
                    check_eq("done_cyc", cyc, d.cyc);
                end
            end
            p1 = out_1; p2 = out_2;
        end
    end

    task automatic refill(input int n1, input int n2);
        int n;
        n = (n1 > n2) ? n1 : n2;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            refill_1 = (i < n1);
            refill_2 = (i < n2);
            if (i < n1 && m1 < CNT_MAX) m1++;
            if (i < n2 && m2 < CNT_MAX) m2++;
        end
        @(negedge clk);
        refill_1 = 1'b0;
        refill_2 = 1'b0;
    endtask

    // Returns the edge count of the accepting edge; queues expected coins and done.
    task automatic start_req(input int amt, output int a);
        int t, r, n;
        done_t d;
        t = 0;
        @(negedge clk);
        while (!req_ready && t < 200) begin @(negedge clk); t++; end
        if (!req_ready) check_eq("ready_timeout", 0, 1);
        r = amt; n = 0;
        while (r >= 2 && m2 > 0) begin coinq.push_back(2); r -= 2; m2--; n++; end
        while (r >= 1 && m1 > 0) begin coinq.push_back(1); r -= 1; m1--; n++; end
        req_valid = 1'b1;
        req_amt   = AMT_W'(amt);
        @(posedge clk);
        #1;
        a = cyc;
        req_valid = 1'b0;
        // Done state is observed after edge a + N*(1+PULSE+GAP) + 1.
        d.sh  = r;
        d.cyc = a + n * (1 + PULSE_LEN + GAP_LEN) + 1;
        doneq.push_back(d);
    endtask

    task automatic wait_done(input string tag);
        int t;
        t = 0;
        while (doneq.size() != 0 && t < 300) begin @(negedge clk); t++; end
        if (doneq.size() != 0) begin
            check_eq({tag, "_done_timeout"}, 0, 1);
            doneq.delete();
        end
        check_eq({tag, "_coins_left"}, coinq.size(), 0);
        coinq.delete();
        check_eq({tag, "_cnt_1"}, int'(cnt_1), m1);
        check_eq({tag, "_cnt_2"}, int'(cnt_2), m2);
    endtask

    initial begin
        int a, t;

        // Reset with random inputs
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            req_valid = 1'($urandom);
            req_amt   = AMT_W'($urandom);
            refill_1  = 1'($urandom);
            refill_2  = 1'($urandom);
        end
        @(negedge clk);
        req_valid = 1'b0; refill_1 = 1'b0; refill_2 = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        check_eq("rst_out_1", int'(out_1), 0);
        check_eq("rst_out_2", int'(out_2), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_done", int'(done), 0);
        check_eq("rst_short", int'(short_amt), 0);
        check_eq("rst_cnt_1", int'(cnt_1), 0);
        check_eq("rst_cnt_2", int'(cnt_2), 0);
        check_eq("rst_ready", int'(req_ready), 1);

        // Full payout: 5 = 2 + 2 + 1
        refill(3, 3);
        start_req(5, a);
        check_eq("busy_run", int'(busy), 1);
        wait_done("full");
        check_eq("full_cnt_1_abs", int'(cnt_1), 2);
        check_eq("full_cnt_2_abs", int'(cnt_2), 1);

        // Drain to cnt_2=0, cnt_1=1, then shortfall on request 3
        start_req(2, a); wait_done("drain2");
        start_req(1, a); wait_done("drain1");
        start_req(3, a); wait_done("short");
        check_eq("short_cnt_1_abs", int'(cnt_1), 0);

        // Zero request
        start_req(0, a);
        check_eq("zero_ready_e1", int'(req_ready), 0);
        @(posedge clk); #1;
        check_eq("zero_ready_e2", int'(req_ready), 0);
        check_eq("zero_done_e2", int'(done), 1);
        wait_done("zero");

        // Refill and eject on the same counter in the PICK cycle
        refill(0, 2);
        start_req(2, a);
        refill_2 = 1'b1;
        m2++;
        @(posedge clk); #1;
        refill_2 = 1'b0;
        check_eq("inv_net", int'(cnt_2), 2);
        wait_done("net");

        // Saturation of type-1 inventory
        refill(16, 0);
        check_eq("sat_cnt_1", int'(cnt_1), CNT_MAX);

        // Reset mid-pulse
        refill(0, 2);
        start_req(4, a);
        t = 0;
        while (!out_2 && t < 50) begin @(negedge clk); t++; end
        check_eq("mid_out_2_seen", int'(out_2), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check_eq("mid_out_2", int'(out_2), 0);
        check_eq("mid_busy", int'(busy), 0);
        check_eq("mid_ready", int'(req_ready), 1);
        coinq.delete();
        doneq.delete();
        m1 = 0; m2 = 0;
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check_eq("mid_cnt_1", int'(cnt_1), 0);
        check_eq("mid_cnt_2", int'(cnt_2), 0);

        // Recovery: a fresh request completes normally
        refill(1, 1);
        start_req(3, a);
        wait_done("recover");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vm_change_dispenser.md
Name: vm_change_dispenser

Overview:
- Coin payout unit for the vending machine; the outbound counterpart of the coin-acceptance path.
- Coin acceptance turns coin pulses into credit. This block turns a change amount into a train of type-1 (value 1) and type-2 (value 2) coin eject pulses.
- It draws from an internal coin inventory.
- It reports any amount it could not pay out, so the controller can show or retain the shortfall.

Parameters:
- AMT_W, 4, width of change amount and shortfall.
- CNT_W, 4, width of each coin inventory counter. Counters saturate at 2^CNT_W-1.
- PULSE_LEN, 2, cycles each eject pulse is held high. Legal range 1..15.
- GAP_LEN, 1, low cycles after each pulse before the next coin is chosen. Legal range 1..15.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  change request present.
- req_amt  in  AMT_W  change amount in coin units.
- req_ready  out  1  high only in IDLE; a request is accepted on a clk edge where req_valid and req_ready are both high.
- refill_1  in  1  per-cycle strobe; adds one type-1 coin to inventory.
- refill_2  in  1  per-cycle strobe; adds one type-2 coin to inventory.
- out_1  out  1  type-1 eject pulse.
- out_2  out  1  type-2 eject pulse.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle completion strobe.
- short_amt  out  AMT_W  unpaid remainder of the last request. Valid from done; held until the next accept.
- cnt_1  out  CNT_W  type-1 inventory.
- cnt_2  out  CNT_W  type-2 inventory.

Behaviour:
- Reset:
  - state=IDLE.
  - out_1, out_2, busy, done = 0.
  - short_amt = 0, cnt_1 = 0, cnt_2 = 0, internal remaining = 0.
  - req_ready = 1 from the first cycle after reset.
- Reset mid-operation has priority over everything. On the next edge, pulses drop, the request is discarded and no done is issued.
- State IDLE:
  - On accept, latch remaining=req_amt and go to PICK.
- State PICK (exactly one cycle), greedy selection:
  - If remaining>=2 and cnt_2>0: remaining-=2, cnt_2-=1, go to PULSE with out_2=1.
  - Else if remaining>=1 and cnt_1>0: remaining-=1, cnt_1-=1, go to PULSE with out_1=1.
  - Else go to DONE with short_amt=remaining (0 if fully paid).
  - When remaining>=2 and cnt_2=0, type-1 coins are used one at a time.
- State PULSE:
  - The selected out_x is high for exactly PULSE_LEN cycles; the other output stays 0.
  - Then go to GAP.
  - out_1 and out_2 are never high together.
- State GAP:
  - Both outputs low for GAP_LEN cycles, then go to PICK.
- State DONE:
  - done=1 for one cycle, then go to IDLE.
  - busy=1 during DONE.
  - req_ready=0 during DONE.
- Latency:
  - Each coin costs 1+PULSE_LEN+GAP_LEN cycles.
  - With accept at edge E, done is high in cycle E+N*(1+PULSE_LEN+GAP_LEN)+2, where N is the number of coins ejected.
- Inventory arithmetic:
  - Refill increments the counter, saturating at max; the saturated refill is lost.
  - Refill and eject decrement on the same counter in the same cycle give a net change of 0.
  - Refill is accepted in every state, including while busy.
- Width rules:
  - req_amt up to 2^AMT_W-1 is fully supported.
  - remaining never underflows; the subtraction is guarded by the comparisons above.
- req_valid while busy is ignored, not queued; the requester holds it until req_ready.

Test Plan:
- Reset: assert rst for 2 cycles with random inputs -> all outputs 0, req_ready=1, cnt_1=cnt_2=0 in the cycle after release.
- Full payout (PULSE_LEN=2, GAP_LEN=1): refill to cnt_2=3, cnt_1=3; request 5 at edge E ->
  - out_2 pulses twice, then out_1 once, each 2 cycles wide with a 1-cycle gap.
  - done in cycle E+14 with short_amt=0.
  - Final cnt_2=1, cnt_1=2.
- Shortfall: cnt_2=0, cnt_1=1, request 3 -> exactly one out_1 pulse; done with short_amt=2; cnt_1=0.
- Zero request: request 0 -> no pulses; done in cycle E+2, short_amt=0; req_ready low in cycles E+1 and E+2.
- Inventory boundary:
  - refill_2 in the same PICK cycle that ejects a type-2 coin, with cnt_2=2 -> cnt_2 stays 2.
  - 16 refill_1 strobes from 0 -> cnt_1 saturates at 15.
- Reset mid-pulse: assert rst while out_2=1 -> out_2=0, busy=0, req_ready=1 on the next edge; no done ever appears for that request.
